// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: start/ready request bus and serial output bundle for
// seq_pattern_gen. The master side issues requests and consumes the stream.
// The slave side is the generator itself.
interface seq_pattern_gen_if #(
    parameter int WIDTH = 4,
    parameter int RPT_W = 4,
    parameter int GAP_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [RPT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             ready;
    logic             busy;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             done;

    modport master (
        output start, pattern, repeat_cnt, gap,
        input  ready, busy, dout, dout_valid, frame_start, done
    );

    modport slave (
        input  start, pattern, repeat_cnt, gap,
        output ready, busy, dout, dout_valid, frame_start, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter.
// - Accepts a WIDTH-bit pattern, a repeat count and an inter-frame gap on a
//   start/ready handshake.
// - Shifts the pattern out MSB-first the requested number of times, with idle
//   gap cycles between repetitions.
// - All outputs are registered.
// Optional build macro SEQ_GEN_PRBS_FILL_EN: non-valid cycles carry a 7-bit
// LFSR (x^7+x^6+1) filler bit instead of a constant 0.
module seq_pattern_gen #(
    parameter int WIDTH = 4,
    parameter int RPT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_pattern_gen_if.slave  bus
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;     // index of the bit currently on dout
    logic [RPT_W-1:0] rpt_left_q, rpt_left_d;   // repetitions still to send after this one
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;     // gap cycles left, including the current one
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] shift_q, shift_d;         // remaining bits, next bit at the MSB

    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic dout_q, dout_d;
    logic dout_valid_q, dout_valid_d;
    logic frame_start_q, frame_start_d;
    logic done_q, done_d;

    logic             filler;
    logic             launch;
    logic [WIDTH-1:0] launch_pat;

    // Next-state and next-output logic for the IDLE/SHIFT/GAP sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        rpt_left_d    = rpt_left_q;
        gap_cnt_d     = gap_cnt_q;
        gap_d         = gap_q;
        pat_d         = pat_q;
        shift_d       = shift_q;
        ready_d       = 1'b0;
        busy_d        = 1'b1;
        dout_d        = filler;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        launch        = 1'b0;
        launch_pat    = pat_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (bus.start) begin
                    pat_d      = bus.pattern;
                    gap_d      = bus.gap;
                    // A repeat count of 0 means one repetition, so nothing is left after it.
                    rpt_left_d = (bus.repeat_cnt == '0) ? '0 : bus.repeat_cnt - RPT_W'(1);
                    launch     = 1'b1;
                    launch_pat = bus.pattern;
                end
            end

            SHIFT: begin
                if (bit_idx_q != '0) begin
                    bit_idx_d    = bit_idx_q - IDX_W'(1);
                    dout_d       = shift_q[WIDTH-1];
                    shift_d      = shift_q << 1;
                    dout_valid_d = 1'b1;
                end else if (rpt_left_q != '0) begin
                    rpt_left_d = rpt_left_q - RPT_W'(1);
                    if (gap_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                    end else begin
                        // A gap of 0 starts the next repetition with no bubble.
                        launch = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    launch = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A frame begins: put the MSB on dout and queue the rest behind it.
        if (launch) begin
            state_d       = SHIFT;
            bit_idx_d     = IDX_W'(WIDTH - 1);
            gap_cnt_d     = '0;
            dout_d        = launch_pat[WIDTH-1];
            shift_d       = launch_pat << 1;
            dout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
            ready_d       = 1'b0;
            busy_d        = 1'b1;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            rpt_left_q    <= '0;
            gap_cnt_q     <= '0;
            gap_q         <= '0;
            pat_q         <= '0;
            shift_q       <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values no matter in which order these lines run.
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            rpt_left_q    <= rpt_left_d;
            gap_cnt_q     <= gap_cnt_d;
            gap_q         <= gap_d;
            pat_q         <= pat_d;
            shift_q       <= shift_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

`ifdef SEQ_GEN_PRBS_FILL_EN
    logic [6:0] lfsr_q, lfsr_d;

    assign filler = lfsr_q[6];

    // The LFSR steps only on edges that drive a filler (non-valid) cycle.
    always_comb begin
        lfsr_d = lfsr_q;
        if (!dout_valid_d) begin
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    // LFSR register; the seed of all ones gives seven 1s and then a 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 7'h7F;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign filler = 1'b0;
`endif

    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.done        = done_q;

endmodule
